mips_mem_arbiter: RTL and testbench

Shares one single-port unified memory between the MIPS instruction-fetch path and the data-memory (load/store) path. Each requester issues a held request and receives a one-cycle acknowledge with read data. The memory side is a variable-latency request/ready port. The block sits between the `mips` core's IF/MEM stages and the memory model, and adds a watchdog that terminates hung memory accesses.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mips_arb_timer.sv | 40 ++++
 rtl/mips_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS unified-memory arbiter.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  // Counter must hold TIMEOUT itself; keep at least one bit when disabled.
  function automatic int timer_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/mips_arb_timer.sv
// Watchdog counter for the memory arbiter: counts BUSY cycles without mem_ready
// and flags expiry once TIMEOUT is reached (TIMEOUT=0 never expires).
module mips_arb_timer
  import mips_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = timer_width(TIMEOUT);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign expired = (TIMEOUT != 0) && (count_reg == CW'(TIMEOUT));

  // Saturates at TIMEOUT so the flag stays up until the FSM clears it.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && !expired && (TIMEOUT != 0)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter between MIPS fetch (IF) and load/store (DM) paths.
// Optional MIPS_ARB_RR_EN selects round-robin on ties instead of fixed DM priority.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ack,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W/8-1:0]   dm_be,
  output logic                  dm_ack,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          state_reg, state_next;
  req_id_t             grant_reg, grant_next;
  logic                mem_req_reg, mem_req_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [BE_W-1:0]     mem_be_reg, mem_be_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                if_ack_reg, if_ack_next;
  logic                dm_ack_reg, dm_ack_next;
  logic                err_reg, err_next;
  logic                pick_dm;
  logic                timer_clear;
  logic                timer_enable;
  logic                timer_expired;

`ifdef MIPS_ARB_RR_EN
  req_id_t             last_grant_reg, last_grant_next;
`endif

  mips_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_be_next    = mem_be_reg;
    rdata_next     = rdata_reg;
    if_ack_next    = 1'b0;
    dm_ack_next    = 1'b0;
    err_next       = 1'b0;
    timer_clear    = 1'b0;
    timer_enable   = 1'b0;
`ifdef MIPS_ARB_RR_EN
    last_grant_next = last_grant_reg;
    // On a tie, DM wins only if IF was the last one served.
    pick_dm = dm_req && (!if_req || (last_grant_reg == REQ_IF));
`else
    pick_dm = dm_req;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (dm_req || if_req) begin
          state_next   = ST_BUSY;
          mem_req_next = 1'b1;
          timer_clear  = 1'b1;
          if (pick_dm) begin
            grant_next     = REQ_DM;
            mem_we_next    = dm_we;
            mem_addr_next  = dm_addr;
            mem_wdata_next = dm_wdata;
            mem_be_next    = dm_be;
          end else begin
            grant_next     = REQ_IF;
            mem_we_next    = 1'b0;
            mem_addr_next  = if_addr;
            mem_wdata_next = '0;
            mem_be_next    = '1;
          end
`ifdef MIPS_ARB_RR_EN
          last_grant_next = pick_dm ? REQ_DM : REQ_IF;
`endif
        end
      end

      ST_BUSY: begin
        timer_enable = !mem_ready;
        // A ready in the expiry cycle still completes the access normally.
        if (mem_ready || timer_expired) begin
          state_next   = ST_RESP;
          mem_req_next = 1'b0;
          if_ack_next  = (grant_reg == REQ_IF);
          dm_ack_next  = (grant_reg == REQ_DM);
          if (mem_ready) begin
            rdata_next = mem_we_reg ? '0 : mem_rdata;
          end else begin
            rdata_next = '0;
            err_next   = 1'b1;
          end
        end
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next   = ST_IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= REQ_IF;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      rdata_reg     <= '0;
      if_ack_reg    <= 1'b0;
      dm_ack_reg    <= 1'b0;
      err_reg       <= 1'b0;
`ifdef MIPS_ARB_RR_EN
      last_grant_reg <= REQ_IF;
`endif
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_be_reg    <= mem_be_next;
      rdata_reg     <= rdata_next;
      if_ack_reg    <= if_ack_next;
      dm_ack_reg    <= dm_ack_next;
      err_reg       <= err_next;
`ifdef MIPS_ARB_RR_EN
      last_grant_reg <= last_grant_next;
`endif
    end
  end

  assign if_ack    = if_ack_reg;
  assign dm_ack    = dm_ack_reg;
  assign if_rdata  = rdata_reg;
  assign dm_rdata  = rdata_reg;
  assign err       = err_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter (TIMEOUT=4); expectation of the tie test
// follows MIPS_ARB_RR_EN.
module tb_mips_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mips_mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    dm_be     = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [31:0] exp_grant [4];
  int seen;
  int cyc_prev;

  initial begin
`ifdef MIPS_ARB_RR_EN
    exp_grant = '{32'd2, 32'd1, 32'd2, 32'd1};
`else
    exp_grant = '{32'd2, 32'd2, 32'd2, 32'd2};
`endif

    // Reset state
    do_reset();
    check("rst_if_ack", {31'b0, if_ack}, 32'd0);
    check("rst_dm_ack", {31'b0, dm_ack}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", if_rdata, 32'd0);

    // IF fetch, zero-wait memory
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    step();
    check("if_mem_req", {31'b0, mem_req}, 32'd1);
    check("if_mem_addr", mem_addr, 32'h0000_0040);
    check("if_mem_we", {31'b0, mem_we}, 32'd0);
    check("if_no_ack_yet", {31'b0, if_ack}, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h2002_0005;
    step();
    check("if_ack", {31'b0, if_ack}, 32'd1);
    check("if_rdata", if_rdata, 32'h2002_0005);
    check("if_dm_ack", {31'b0, dm_ack}, 32'd0);
    check("if_mem_req_drop", {31'b0, mem_req}, 32'd0);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();
    check("if_ack_pulse", {31'b0, if_ack}, 32'd0);

    // DM store with 3 wait states
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_addr   = 32'h0000_0010;
    dm_wdata  = 32'hDEAD_BEEF;
    dm_be     = 4'b0011;
    mem_rdata = 32'h1234_5678;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      check("st_mem_req", {31'b0, mem_req}, 32'd1);
      check("st_mem_we", {31'b0, mem_we}, 32'd1);
      check("st_mem_addr", mem_addr, 32'h0000_0010);
      check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("st_mem_be", {28'b0, mem_be}, 32'h3);
      check("st_no_ack", {31'b0, dm_ack}, 32'd0);
    end
    mem_ready = 1'b1;
    step();
    check("st_ack", {31'b0, dm_ack}, 32'd1);
    check("st_rdata_zero", dm_rdata, 32'd0);
    check("st_err", {31'b0, err}, 32'd0);
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    mem_ready = 1'b0;
    step();
    check("st_ack_pulse", {31'b0, dm_ack}, 32'd0);

    // Both requesters held, zero-wait memory
    do_reset();
    if_req    = 1'b1;
    if_addr   = 32'h0000_0100;
    dm_req    = 1'b1;
    dm_addr   = 32'h0000_0200;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    seen      = 0;
    cyc_prev  = 0;
    for (int c = 0; c < 20 && seen < 4; c++) begin
      step();
      if (if_ack || dm_ack) begin
        check("tie_grant", {30'b0, dm_ack, if_ack}, exp_grant[seen]);
        if (seen > 0) check("tie_gap", 32'(c - cyc_prev), 32'd3);
        cyc_prev = c;
        seen++;
        if (seen == 4) begin
          if_req = 1'b0;
          dm_req = 1'b0;
        end
      end
    end
    check("tie_count", 32'(seen), 32'd4);
    mem_ready = 1'b0;
    step();
    step();

    // Watchdog: DM load, memory never ready
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h0000_0300;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    check("to_mem_req", {31'b0, mem_req}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("to_no_ack", {31'b0, dm_ack}, 32'd0);
    end
    step();
    check("to_ack", {31'b0, dm_ack}, 32'd1);
    check("to_err", {31'b0, err}, 32'd1);
    check("to_rdata", dm_rdata, 32'd0);
    check("to_mem_req_drop", {31'b0, mem_req}, 32'd0);
    dm_req = 1'b0;
    step();
    check("to_err_pulse", {31'b0, err}, 32'd0);

    // Normal access after a timeout
    if_req  = 1'b1;
    if_addr = 32'h0000_0080;
    step();
    check("post_to_addr", mem_addr, 32'h0000_0080);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    step();
    check("post_to_ack", {31'b0, if_ack}, 32'd1);
    check("post_to_rdata", if_rdata, 32'hCAFE_0001);
    check("post_to_err", {31'b0, err}, 32'd0);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();

    // Reset during BUSY abandons the access
    dm_req  = 1'b1;
    dm_addr = 32'h0000_0020;
    step();
    check("rb_mem_req", {31'b0, mem_req}, 32'd1);
    reset  = 1'b1;
    dm_req = 1'b0;
    step();
    check("rb_mem_req_drop", {31'b0, mem_req}, 32'd0);
    check("rb_mem_addr", mem_addr, 32'd0);
    check("rb_dm_ack", {31'b0, dm_ack}, 32'd0);
    check("rb_rdata", dm_rdata, 32'd0);
    reset     = 1'b0;
    mem_ready = 1'b1;
    step();
    check("rb_no_ack", {30'b0, dm_ack, if_ack}, 32'd0);

    // mem_ready in IDLE is ignored
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("idle_rdy_ack", {30'b0, dm_ack, if_ack}, 32'd0);
    check("idle_rdy_mem_req", {31'b0, mem_req}, 32'd0);
    step();
    check("idle_rdy_ack2", {30'b0, dm_ack, if_ack}, 32'd0);
    if_req  = 1'b1;
    if_addr = 32'h0000_0044;
    step();
    check("idle_rdy_next_req", {31'b0, mem_req}, 32'd1);
    check("idle_rdy_next_ack", {31'b0, if_ack}, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_00A5;
    step();
    check("idle_rdy_next_done", {31'b0, if_ack}, 32'd1);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
